// File: rtl/lvds_adc_tx.sv
// rtl/lvds_adc_tx.sv - two-lane serial ADC transmitter (frame lane plus data lanes A/B)
// Optional feature macro: ADC_TX_RAMP_EN enables the ramp generator for test_mode 2.
module lvds_adc_tx (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [1:0]  test_mode_i,
    input  logic        slip_i,
    input  logic        underrun_clr_i,
    output logic        out_a_o,
    output logic        out_b_o,
    output logic        fr_out_o,
    output logic        frame_start_o,
    output logic        underrun_o
);
    localparam logic [7:0]  FR_PATTERN = 8'h0F;
    localparam logic [15:0] TEST_WORD  = 16'hA55A;

    logic [2:0]  bcnt_q;
    logic [15:0] shift_q;
    logic [15:0] hold_q, hold_d;
    logic        phase_q, phase_d;
    logic        slip_pending_q;
    logic        out_a_q, out_b_q, fr_q, fs_q, underrun_q;
    logic [15:0] word_d;
    logic        under_set;
    logic        boundary, load;
`ifdef ADC_TX_RAMP_EN
    logic [15:0] ramp_q, ramp_d;
`endif

    assign boundary  = (bcnt_q == 3'd7);
    assign load      = boundary && !slip_pending_q;
    assign s_ready_o = load && !reset_i;

    always_comb begin
        word_d    = TEST_WORD;
        hold_d    = hold_q;
        phase_d   = phase_q;
        under_set = 1'b0;
`ifdef ADC_TX_RAMP_EN
        ramp_d    = ramp_q;
`endif
        if (load) begin
            case (test_mode_i)
                2'd0: begin
                    if (s_valid_i) begin
                        word_d = s_data_i;
                        hold_d = s_data_i;
                    end else begin
                        word_d    = hold_q;
                        under_set = 1'b1;
                    end
                end
                2'd1: word_d = TEST_WORD;
                2'd2: begin
`ifdef ADC_TX_RAMP_EN
                    word_d = ramp_q;
                    ramp_d = ramp_q + 16'd1;
`else
                    word_d = TEST_WORD;
`endif
                end
                default: begin
                    word_d  = phase_q ? 16'h5555 : 16'hAAAA;
                    phase_d = ~phase_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bcnt_q         <= 3'd7;
            shift_q        <= 16'd0;
            hold_q         <= 16'd0;
            phase_q        <= 1'b0;
            slip_pending_q <= 1'b0;
            out_a_q        <= 1'b0;
            out_b_q        <= 1'b0;
            fr_q           <= 1'b0;
            fs_q           <= 1'b0;
            underrun_q     <= 1'b0;
`ifdef ADC_TX_RAMP_EN
            ramp_q         <= 16'd0;
`endif
        end else begin
            hold_q         <= hold_d;
            phase_q        <= phase_d;
`ifdef ADC_TX_RAMP_EN
            ramp_q         <= ramp_d;
`endif
            underrun_q     <= under_set | (underrun_q & ~underrun_clr_i);
            // A pending slip is consumed at a boundary; a new pulse there re-arms it.
            slip_pending_q <= (boundary ? 1'b0 : slip_pending_q) | slip_i;
            if (load) begin
                bcnt_q  <= 3'd0;
                out_b_q <= word_d[15];
                out_a_q <= word_d[7];
                fr_q    <= FR_PATTERN[7];
                fs_q    <= 1'b1;
                shift_q <= {word_d[14:8], 1'b0, word_d[6:0], 1'b0};
            end else if (!boundary) begin
                bcnt_q  <= bcnt_q + 3'd1;
                out_b_q <= shift_q[15];
                out_a_q <= shift_q[7];
                fr_q    <= FR_PATTERN[3'd6 - bcnt_q];
                fs_q    <= 1'b0;
                shift_q <= {shift_q[14:8], 1'b0, shift_q[6:0], 1'b0};
            end
        end
    end

    assign out_a_o       = out_a_q;
    assign out_b_o       = out_b_q;
    assign fr_out_o      = fr_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_lvds_adc_tx.sv
// tb/tb_lvds_adc_tx.sv - self-checking bench for lvds_adc_tx against a frame-level bit-stream model
module tb_lvds_adc_tx;
    localparam logic [7:0]  FR_PATTERN = 8'h0F;
    localparam logic [15:0] TEST_WORD  = 16'hA55A;

    logic        clk = 1'b0;
    logic        reset, s_valid, s_ready, slip, underrun_clr;
    logic [15:0] s_data;
    logic [1:0]  test_mode;
    logic        out_a, out_b, fr_out, frame_start, underrun;

    always #5 clk = ~clk;

    lvds_adc_tx dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .s_data_i       (s_data),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .test_mode_i    (test_mode),
        .slip_i         (slip),
        .underrun_clr_i (underrun_clr),
        .out_a_o        (out_a),
        .out_b_o        (out_b),
        .fr_out_o       (fr_out),
        .frame_start_o  (frame_start),
        .underrun_o     (underrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: queue of {frame_start, fr, b, a} tuples still owed on the wire.
    logic [3:0]  q[$];
    logic [3:0]  cur;
    logic        m_pend, m_phase, m_und, acc;
    logic [15:0] m_hold, m_ramp;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [15:0] d,
                        input logic [1:0] m, input logic sl, input logic clr);
        logic        bnd, exp_rdy, set_u;
        logic [15:0] w;
        reset = rst; s_valid = v; s_data = d; test_mode = m; slip = sl; underrun_clr = clr;
        #1;
        bnd     = (q.size() == 0);
        exp_rdy = bnd && !m_pend && !rst;
        check("s_ready", s_ready, exp_rdy);
        acc = exp_rdy && v;
        @(posedge clk);
        set_u = 1'b0;
        if (rst) begin
            q.delete();
            cur = 4'd0; m_pend = 0; m_phase = 0; m_und = 0; m_hold = 0; m_ramp = 0;
        end else begin
            if (bnd && m_pend) begin
                q.push_back(cur);
                m_pend = sl;
            end else begin
                if (bnd) begin
                    case (m)
                        2'd0: if (v) begin w = d; m_hold = d; end
                              else begin w = m_hold; set_u = 1'b1; end
                        2'd1: w = TEST_WORD;
`ifdef ADC_TX_RAMP_EN
                        2'd2: begin w = m_ramp; m_ramp = m_ramp + 16'd1; end
`else
                        2'd2: w = TEST_WORD;
`endif
                        default: begin w = m_phase ? 16'h5555 : 16'hAAAA; m_phase = !m_phase; end
                    endcase
                    for (int k = 0; k < 8; k++)
                        q.push_back({k == 0, FR_PATTERN[7-k], w[15-k], w[7-k]});
                end
                m_pend = m_pend | sl;
            end
            m_und = set_u ? 1'b1 : (clr ? 1'b0 : m_und);
        end
        @(negedge clk);
        if (q.size() > 0) cur = q.pop_front();
        check("out_b", out_b, cur[1]);
        check("out_a", out_a, cur[0]);
        check("fr_out", fr_out, cur[2]);
        check("frame_start", frame_start, cur[3]);
        check("underrun", underrun, m_und);
    endtask

    initial begin
        logic [15:0] words [3];
        int idx;
        logic [1:0] mode;
        cur = 4'd0; m_pend = 0; m_phase = 0; m_und = 0; m_hold = 0; m_ramp = 0; acc = 0;
        reset = 1; s_valid = 0; s_data = 0; test_mode = 0; slip = 0; underrun_clr = 0;
        @(negedge clk);
        repeat (3) step(1, 0, 16'h0, 2'd0, 0, 0);

        repeat (40) step(0, 1, 16'hA55A, 2'd0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 16'h1234, 2'd0, 0, 0);
            if (acc) break;
        end
        repeat (30) step(0, 0, 16'($urandom), 2'd0, 0, 0);
        step(0, 0, 16'h0, 2'd0, 0, 1);
        repeat (3) step(0, 0, 16'h0, 2'd0, 0, 0);
        repeat (12) step(0, 0, 16'h0, 2'd0, 0, 1);

        words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
        for (int pass = 0; pass < 2; pass++) begin
            idx = 0;
            for (int c = 0; c < 80 && idx < 3; c++) begin
                step(0, 1, words[idx], 2'd0,
                     (c == 3) || (pass == 1 && c == 5), 0);
                if (acc) idx++;
            end
            repeat (20) step(0, 1, 16'($urandom), 2'd0, 0, 0);
        end

        repeat (40) step(0, 1'($urandom_range(0, 1)), 16'($urandom), 2'd1, 0, 0);
        repeat (40) step(0, 1'($urandom_range(0, 1)), 16'($urandom), 2'd2, 0, 0);
        repeat (40) step(0, 1'($urandom_range(0, 1)), 16'($urandom), 2'd3, 0, 0);

        for (int i = 0; i < 20 && q.size() != 4; i++)
            step(0, 0, 16'h0, 2'd0, 0, 0);
        step(1, 1, 16'h0, 2'd2, 0, 0);
        repeat (30) step(0, 0, 16'h0, 2'd2, 0, 0);

        mode = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
                 mode, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lvds_adc_tx.md
# lvds_adc_tx

Two-lane serial ADC transmitter: the transmit end of the two-lane LVDS ADC link (frame lane plus data lanes A/B) that the ISERDES receiver deserialises. Accepts 16-bit sample words over a valid/ready handshake and serialises each one MSB-first across two lanes, 8 bits per lane per frame, alongside a frame-clock pattern lane. Serves as the ADC emulator for receiver bring-up and loopback. It also supplies test patterns and a one-bit frame slip for exercising receiver bitslip alignment.

## Interface
- FR_PATTERN, 8'h0F: frame-lane bit pattern per frame, sent bit 7 first.
- TEST_WORD, 16'hA55A: constant word sent in test_mode 1.
- clk  in  1  bit clock; one serial bit per lane per cycle.
- reset  in  1  synchronous, active-high.
- s_data  in  16  sample word; [15:8] to lane B, [7:0] to lane A.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- test_mode  in  2  0 normal, 1 TEST_WORD, 2 ramp, 3 alternating 16'hAAAA/16'h5555.
- slip  in  1  pulse; lengthens one future frame by one bit.
- underrun_clr  in  1  clears underrun.
- out_a  out  1  lane A serial data.
- out_b  out  1  lane B serial data.
- fr_out  out  1  frame-lane serial pattern.
- frame_start  out  1  high during the first bit cycle of each frame.
- underrun  out  1  sticky; a normal-mode boundary had no valid word.

## Operation
- 3-bit bit counter bcnt counts 0..7. bcnt==7 is the frame boundary cycle.
- s_ready = (bcnt==7) && !slip_pending && !reset. This is combinational from registers.
- Boundary, no slip pending: load shift register, set bcnt to 0. The load source depends on test_mode, which is sampled only here:
  - Mode 0: s_data if s_valid, else the last accepted word (hold register). In the no-s_valid case also set underrun.
  - Mode 1: TEST_WORD.
  - Mode 2: ramp register; ramp then increments, wrapping 16'hFFFF to 0.
  - Mode 3: 16'hAAAA when phase==0, 16'h5555 when phase==1; phase then toggles.
  - Modes 1-3: s_ready still asserts. Any offered word is consumed and discarded, and the hold register is not updated. underrun is never set.
- Slip:
  - A slip pulse sets slip_pending. Extra pulses while pending coalesce into one.
  - At the next boundary with slip_pending=1: bcnt stays 7, all outputs repeat their previous values, s_ready=0, and slip_pending clears.
  - The load then happens on the following cycle. Result: exactly one 9-cycle frame, and no word is lost.
  - A slip arriving in a boundary cycle acts at the next boundary.
- underrun: set-dominant over underrun_clr in the same cycle.

## Timing
- All outputs except s_ready are registered.
- Word accepted in cycle N: bit 15 on out_b and bit 7 on out_a in cycle N+1. Last bits (8 and 0) in cycle N+8.
- fr_out = FR_PATTERN[7-k] in bit cycle k, aligned with data.
- frame_start is high in cycle N+1.
- In steady state s_ready pulses once every 8 cycles, or once in 9 for a slipped frame.
- Reset state:
  - bcnt=7; out_a, out_b, fr_out, frame_start, underrun = 0.
  - Shift, hold, ramp, phase and slip_pending = 0.
  - s_ready=0 while reset is high.
- First cycle after reset release: boundary cycle, s_ready=1.
- Reset mid-frame: outputs are 0 in the next cycle; the partial frame is abandoned.

## Configuration
- ADC_TX_RAMP_EN defined: the 16-bit ramp register exists and test_mode 2 behaves as specified.
- ADC_TX_RAMP_EN undefined: no ramp register; test_mode 2 behaves exactly like test_mode 1 (TEST_WORD).

## Test plan
- Continuous stream, s_valid=1, s_data=16'hA55A, mode 0 -> out_b 1,0,1,0,0,1,0,1 and out_a 0,1,0,1,1,0,1,0 repeating from cycle N+1; fr_out 0,0,0,0,1,1,1,1; frame_start every 8 cycles; underrun=0.
- Accept a single word 16'h1234, then s_valid=0 -> 16'h1234 repeats every frame; underrun=1 after the first empty boundary; underrun_clr pulse clears it; a new set still wins over a simultaneous clear.
- slip pulse mid-frame in stream 0x0001, 0x0002, 0x0003 -> exactly one frame_start interval of 9, last bit held one extra cycle, all three words transmitted in order, following intervals back to 8; double slip pulse before the boundary -> still only one 9-cycle frame.
- test_mode=2 with ADC_TX_RAMP_EN -> frames 0x0000, 0x0001, 0x0002...; ramp preset by running 65536 frames -> 0xFFFF followed by 0x0000. Without the macro -> TEST_WORD every frame.
- test_mode=3 -> frames alternate 0xAAAA, 0x5555; offered s_data is consumed (s_ready handshakes) but never transmitted.
- reset asserted at bcnt=3 for one cycle -> all outputs 0 next cycle; s_ready=1 on the first cycle after release; underrun and ramp restart at 0.
